rotate_frame_buffer: RTL and testbench
======================================

# rotate_frame_buffer

Parametrised single-frame buffer that accepts a raster-order pixel stream, stores one full frame in on-chip RAM, then replays it rotated by 0/90/180/270 degrees clockwise. It generalises the fixed 256x256 / 24-bit write-then-read adapter: image size and pixel width are parameters, and both sides use valid/ready handshakes with backpressure. Rotation is selected per frame. It sits between the pixel source and the display/output sink of the image-rotate pipeline.

## Interface
- IMG_W, 16: input image width in pixels (>=2).
- IMG_H, 16: input image height in pixels (>=2).
- PIX_W, 24: pixel width in bits.
- AW, $clog2(IMG_W*IMG_H): RAM address width (derived, not overridden).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- rot  in  2  rotation: 0 = none, 1 = 90 CW, 2 = 180, 3 = 270 CW.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  buffer accepts pixels (write phase).
- in_data  in  PIX_W  input pixel, raster order (row 0 col 0 first).
- out_valid  out  1  output pixel valid.
- out_ready  in  1  sink accepts output pixel.
- out_data  out  PIX_W  output pixel, raster order of rotated image.
- out_eol  out  1  qualifies out_data as last pixel of an output row.
- out_eof  out  1  qualifies out_data as last pixel of the frame.

## Operation
- States: WRITE, READ. Reset -> WRITE.
- WRITE: in_ready=1. Each in_valid&&in_ready stores in_data at addr = row*IMG_W+col; col wraps at IMG_W-1 and increments row. When pixel IMG_W*IMG_H-1 is accepted: rot latched into rot_q, state -> READ, in_ready=0 from the next cycle.
- READ: in_ready=0, in_valid ignored. Output counters (orow, ocol) walk the rotated image in raster order. Output width OW = IMG_W for rot 0/2, IMG_H for rot 1/3; OH is the other dimension.
- Source pixel for output (r,c): rot0 src(r,c); rot1 src(IMG_H-1-c, r); rot2 src(IMG_H-1-r, IMG_W-1-c); rot3 src(c, IMG_W-1-r). src(y,x) is addr y*IMG_W+x.
- RAM: inferred single-port, synchronous read, 1-cycle read latency, no output register beyond the 2-entry output buffer.
- Output buffer: 2-entry FIFO feeding out_*. A read is issued only when (entries + reads in flight - pop this cycle) <= 1, so the FIFO never overflows. eol/eof flags travel with their pixel.
- out_eol asserted with pixel where ocol = OW-1; out_eof with the final pixel (also carries eol).
- When the eof pixel handshakes (out_valid&&out_ready&&out_eof): state -> WRITE, counters cleared, in_ready=1 next cycle. RAM contents are not cleared.
- rot changes during WRITE before the last pixel are taken; changes during READ are ignored until the next frame.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_eol=0, out_eof=0; all counters 0; state WRITE; rot_q=0.
- rst asserted mid-frame (either state) aborts the frame; next clean cycle behaves as after power-on reset. No partial output after reset.
- Write throughput: 1 pixel/cycle.
- Read latency: first out_valid no later than 2 cycles after the cycle in which the last input pixel is accepted.
- With out_ready held 1, one output pixel per cycle, no bubbles, until eof.
- out_valid must not drop, and out_data/out_eol/out_eof must not change, while out_valid=1 and out_ready=0.
- Frame turnaround: a new frame's first pixel is accepted the cycle after the eof handshake at the earliest.
- Each frame produces exactly IMG_W*IMG_H output pixels and exactly OH eol pulses.

## Test plan
Bench uses IMG_W=4, IMG_H=3, PIX_W=24, input pixel k = k (0..11), out_ready=1 unless stated.
- rot=0 -> outputs 0..11 in order; eol on 3,7,11; eof on 11; in_ready returns 1 the cycle after eof.
- rot=1 -> 8,4,0, 9,5,1, 10,6,2, 11,7,3; eol every 3rd pixel (4 pulses); eof on 3.
- rot=2 -> 11,10,...,0; eol on 8,4,0; rot=3 -> 3,7,11, 2,6,10, 1,5,9, 0,4,8; eol every 3rd; eof on 8.
- Random out_ready (~50%) with rot=1, plus rot toggled during READ -> same sequence as the rot=1 case, out_data stable whenever stalled, next frame uses the new rot.
- rst pulsed after 5 output pixels -> out_valid=0, in_ready=1 next cycle; new full frame with rot=0 outputs 0..11 correctly; in_valid held 1 during READ never writes RAM (checked by a second frame's output).

Source files
------------

// File: rtl/rotate_frame_buffer.sv
// Single-frame buffer: stores one raster frame, replays it rotated.
// Ports: clk, rst (sync high), rot, in_* stream (valid/ready), out_* stream with eol/eof.
module rotate_frame_buffer #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int PIX_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       rot,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_eol,
  output logic             out_eof
);

  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N);

  localparam logic [AW-1:0] W_L  = AW'(IMG_W);
  localparam logic [AW-1:0] H_L  = AW'(IMG_H);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic {
    S_WRITE,
    S_READ
  } state_e;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             eol;
    logic             eof;
  } ent_t;

  state_e        state_q;
  logic [AW-1:0] waddr_q;
  logic [AW-1:0] orow_q;
  logic [AW-1:0] ocol_q;
  logic [1:0]    rot_q;
  logic          rd_done_q;

  logic          rd_vld_q;
  logic          rd_eol_q;
  logic          rd_eof_q;
  logic [PIX_W-1:0] rdata_q;

  logic [PIX_W-1:0] ram_q [N];

  ent_t          fifo_q [2];
  logic          rptr_q;
  logic          wptr_q;
  logic [1:0]    cnt_q;

  logic [AW-1:0] ow;
  logic [AW-1:0] oh;
  logic          is_eol;
  logic          is_eof;
  logic [AW-1:0] src_y;
  logic [AW-1:0] src_x;
  logic [AW-1:0] raddr;
  logic [AW-1:0] ram_addr;
  logic          we;
  logic          fifo_ne;
  ent_t          head;
  logic          hs;
  logic          eof_hs;
  logic          pop_fifo;
  logic          push;
  logic [2:0]    occ;
  logic          issue;

  // Output geometry swaps for the quarter-turn rotations.
  assign ow = rot_q[0] ? H_L : W_L;
  assign oh = rot_q[0] ? W_L : H_L;

  assign is_eol = (ocol_q == ow - 1'b1);
  assign is_eof = is_eol && (orow_q == oh - 1'b1);

  always_comb begin
    src_y = orow_q;
    src_x = ocol_q;
    unique case (rot_q)
      2'd0: begin
        src_y = orow_q;
        src_x = ocol_q;
      end
      2'd1: begin
        src_y = H_L - 1'b1 - ocol_q;
        src_x = orow_q;
      end
      2'd2: begin
        src_y = H_L - 1'b1 - orow_q;
        src_x = W_L - 1'b1 - ocol_q;
      end
      2'd3: begin
        src_y = ocol_q;
        src_x = W_L - 1'b1 - orow_q;
      end
      default: begin
        src_y = orow_q;
        src_x = ocol_q;
      end
    endcase
  end

  assign raddr = src_y * W_L + src_x;

  assign we       = (state_q == S_WRITE) && in_valid;
  assign in_ready = (state_q == S_WRITE);
  assign ram_addr = (state_q == S_WRITE) ? waddr_q : raddr;

  // A RAM word arriving while the FIFO is empty is presented
  // directly; it is only queued if the sink does not take it.
  assign fifo_ne = (cnt_q != 2'd0);
  assign head    = fifo_q[rptr_q];

  assign out_valid = fifo_ne || rd_vld_q;

  always_comb begin
    out_data = '0;
    out_eol  = 1'b0;
    out_eof  = 1'b0;
    if (fifo_ne) begin
      out_data = head.data;
      out_eol  = head.eol;
      out_eof  = head.eof;
    end else if (rd_vld_q) begin
      out_data = rdata_q;
      out_eol  = rd_eol_q;
      out_eof  = rd_eof_q;
    end
  end

  assign hs       = out_valid && out_ready;
  assign eof_hs   = hs && out_eof;
  assign pop_fifo = fifo_ne && out_ready;
  assign push     = rd_vld_q && (fifo_ne || !out_ready);

  // Pixels held or in flight after this cycle's pop; at most one
  // more read may be issued so the 2-entry FIFO cannot overflow.
  assign occ   = {1'b0, cnt_q} + {2'b0, rd_vld_q} - {2'b0, hs};
  assign issue = (state_q == S_READ) && !rd_done_q && (occ <= 3'd1);

  always_ff @(posedge clk) begin
    if (we) begin
      ram_q[ram_addr] <= in_data;
    end
    rdata_q <= ram_q[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_WRITE;
      waddr_q   <= '0;
      orow_q    <= '0;
      ocol_q    <= '0;
      rot_q     <= 2'd0;
      rd_done_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_eol_q  <= 1'b0;
      rd_eof_q  <= 1'b0;
    end else begin
      rd_vld_q <= issue;
      rd_eol_q <= issue && is_eol;
      rd_eof_q <= issue && is_eof;
      unique case (state_q)
        S_WRITE: begin
          if (in_valid) begin
            if (waddr_q == LAST) begin
              waddr_q <= '0;
              rot_q   <= rot;
              state_q <= S_READ;
            end else begin
              waddr_q <= waddr_q + 1'b1;
            end
          end
        end
        S_READ: begin
          if (issue) begin
            if (is_eol) begin
              ocol_q <= '0;
              orow_q <= orow_q + 1'b1;
              if (is_eof) begin
                rd_done_q <= 1'b1;
              end
            end else begin
              ocol_q <= ocol_q + 1'b1;
            end
          end
          if (eof_hs) begin
            state_q   <= S_WRITE;
            orow_q    <= '0;
            ocol_q    <= '0;
            rd_done_q <= 1'b0;
          end
        end
        default: state_q <= S_WRITE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q <= 1'b0;
      wptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= {rdata_q, rd_eol_q, rd_eof_q};
        wptr_q         <= ~wptr_q;
      end
      if (pop_fifo) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop_fifo};
    end
  end

endmodule

// File: tb/tb_rotate_frame_buffer.sv
// Directed bench for rotate_frame_buffer on a 4x3 frame.
// Checks all rotations, backpressure, mid-frame reset and turnaround.
module tb_rotate_frame_buffer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = 24;
  localparam int NP = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    rot;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic          out_eol;
  logic          out_eof;

  int n_checks = 0;
  int n_errors = 0;

  int exp_tab [4][12] = '{
    '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11},
    '{8, 4, 0, 9, 5, 1, 10, 6, 2, 11, 7, 3},
    '{11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0},
    '{3, 7, 11, 2, 6, 10, 1, 5, 9, 0, 4, 8}
  };

  logic [PW-1:0] got_d [12];
  logic [1:0]    got_f [12];
  int            stall_err;
  int            got_n;

  always #5 clk = ~clk;

  rotate_frame_buffer #(
    .IMG_W(W),
    .IMG_H(H),
    .PIX_W(PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rot      (rot),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_eol  (out_eol),
    .out_eof  (out_eof)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [1:0] r);
    for (int k = 0; k < NP; k++) begin
      int  g;
      bit  acc;
      g   = 0;
      acc = 1'b0;
      in_valid = 1'b1;
      in_data  = PW'(k);
      rot      = r;
      while (!acc && g < 50) begin
        acc = in_ready;
        step();
        g++;
      end
      if (!acc) begin
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout pixel %0d not accepted", k);
      end
    end
    in_valid = 1'b0;
  endtask

  // Collects n handshaken pixels; tracks stability while stalled.
  task automatic capture(input int n, input bit rnd);
    int          cyc;
    bit          rdy;
    bit          prev_stall;
    logic [PW-1:0] pd;
    logic [1:0]  pf;
    stall_err  = 0;
    got_n      = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    pd         = '0;
    pf         = '0;
    while (got_n < n && cyc < 300) begin
      if (prev_stall) begin
        if (out_valid !== 1'b1 || out_data !== pd ||
            {out_eol, out_eof} !== pf)
          stall_err++;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (out_valid === 1'b1 && rdy) begin
        got_d[got_n] = out_data;
        got_f[got_n] = {out_eol, out_eof};
        got_n++;
      end
      prev_stall = (out_valid === 1'b1) && !rdy;
      pd = out_data;
      pf = {out_eol, out_eof};
      step();
      cyc++;
    end
    out_ready = 1'b1;
  endtask

  task automatic cmp_frame(input int r, input string tag);
    int ow;
    ow = (r % 2 == 1) ? H : W;
    n_checks++;
    if (got_n !== NP) begin
      n_errors++;
      $display("FAIL %s_count got %0d want %0d", tag, got_n, NP);
    end
    for (int i = 0; i < got_n; i++) begin
      logic [1:0] ef;
      ef = {((i % ow) == ow - 1) ? 1'b1 : 1'b0,
            (i == NP - 1) ? 1'b1 : 1'b0};
      n_checks++;
      if (got_d[i] !== PW'(exp_tab[r][i])) begin
        n_errors++;
        $display("FAIL %s_data[%0d] got %0d want %0d",
                 tag, i, got_d[i], exp_tab[r][i]);
      end
      n_checks++;
      if (got_f[i] !== ef) begin
        n_errors++;
        $display("FAIL %s_eol_eof[%0d] got %b want %b",
                 tag, i, got_f[i], ef);
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_in_ready got %b want 1", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    n_checks++;
    if (out_data !== '0) begin
      n_errors++;
      $display("FAIL rst_out_data got %0h want 0", out_data);
    end
    n_checks++;
    if ({out_eol, out_eof} !== 2'b00) begin
      n_errors++;
      $display("FAIL rst_flags got %b want 00", {out_eol, out_eof});
    end
  endtask

  task automatic test_rotations();
    for (int r = 0; r < 4; r++) begin
      send_frame(2'(r));
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL rot%0d_in_ready_read got %b want 0", r, in_ready);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL rot%0d_latency out_valid got %b want 1",
                 r, out_valid);
      end
      capture(NP, 1'b0);
      cmp_frame(r, $sformatf("rot%0d", r));
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL rot%0d_turnaround in_ready %b out_valid %b want 1 0",
                 r, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    send_frame(2'd1);
    rot = 2'd2;
    capture(NP, 1'b1);
    cmp_frame(1, "stall_rot1");
    n_checks++;
    if (stall_err !== 0) begin
      n_errors++;
      $display("FAIL stall_stable got %0d violations want 0", stall_err);
    end
    send_frame(2'd3);
    capture(NP, 1'b0);
    cmp_frame(3, "next_rot3");
  endtask

  task automatic test_mid_reset();
    send_frame(2'd2);
    capture(5, 1'b0);
    n_checks++;
    if (got_n !== 5 || got_d[4] !== PW'(7)) begin
      n_errors++;
      $display("FAIL midrst_prefix got n=%0d d=%0d want n=5 d=7",
               got_n, got_d[4]);
    end
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_state out_valid %b in_ready %b want 0 1",
               out_valid, in_ready);
    end
    send_frame(2'd0);
    in_valid = 1'b1;
    in_data  = 24'hABCDEF;
    capture(NP, 1'b0);
    in_valid = 1'b0;
    in_data  = '0;
    cmp_frame(0, "midrst_rot0");
    send_frame(2'd2);
    capture(NP, 1'b0);
    cmp_frame(2, "after_rot2");
  endtask

  initial begin
    rst       = 1'b1;
    rot       = 2'd0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    test_reset();
    test_rotations();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
